// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI byte engine between a
// stream port (A) and a configuration port (B). One byte per grant, with
// start/done timeouts and a forced idle gap between transfers.
module spi_xfer_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int START_TO   = 16,
    parameter int DONE_TO    = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       gnt_a,
    output logic       rvalid_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       gnt_b,
    output logic       rvalid_b,
    output logic [7:0] rdata,
    output logic [7:0] spi_data,
    output logic       spi_valid,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_rddata,
    output logic       timeout_err,
    output logic       owner,
    output logic       arb_busy
);

    localparam int TMAX_CYC = (START_TO > DONE_TO) ? START_TO : DONE_TO;
    localparam int TW       = $clog2(TMAX_CYC) + 1;

    // Terminal counts are one less than the limit: the timer starts at zero
    // on entry, so the abort edge lands exactly LIMIT cycles after entry.
    localparam logic [TW-1:0] START_LIM = TW'(START_TO - 1);
    localparam logic [TW-1:0] DONE_LIM  = TW'(DONE_TO - 1);
    localparam logic [TW-1:0] GAP_LIM   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT = {TW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d, timer_inc_s;
    logic [7:0]      spi_data_q, spi_data_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;      // last winner; the other port is favoured
    logic            gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic            rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic            spi_valid_q, spi_valid_d;
    logic            timeout_err_q, timeout_err_d;
    logic            arb_busy_q;

    // Saturating increment so a stalled state never wraps the timer.
    always_comb begin
        if (timer_q == TIMER_SAT) begin
            timer_inc_s = timer_q;
        end else begin
            timer_inc_s = timer_q + TW'(1);
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        spi_data_d    = spi_data_q;
        rdata_d       = rdata_q;
        owner_d       = owner_q;
        last_d        = last_q;
        gnt_a_d       = 1'b0;
        gnt_b_d       = 1'b0;
        rvalid_a_d    = 1'b0;
        rvalid_b_d    = 1'b0;
        spi_valid_d   = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_a && (!req_b || last_q)) begin
                    gnt_a_d    = 1'b1;
                    spi_data_d = data_a;
                    owner_d    = 1'b0;
                    state_d    = ST_ISSUE;
                end else if (req_b) begin
                    gnt_b_d    = 1'b1;
                    spi_data_d = data_b;
                    owner_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                spi_valid_d = 1'b1;
                timer_d     = '0;
                state_d     = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_done) begin
                    rdata_d    = spi_rddata;
                    rvalid_a_d = ~owner_q;
                    rvalid_b_d = owner_q;
                    state_d    = ST_RESP;
                end else if (spi_busy) begin
                    timer_d = '0;
                    state_d = ST_WAIT_DONE;
                end else if (timer_q >= START_LIM) begin
                    timeout_err_d = 1'b1;
                    last_d        = owner_q;
                    timer_d       = '0;
                    state_d       = ST_GAP;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ST_WAIT_DONE: begin
                if (spi_done) begin
                    rdata_d    = spi_rddata;
                    rvalid_a_d = ~owner_q;
                    rvalid_b_d = owner_q;
                    state_d    = ST_RESP;
                end else if (timer_q >= DONE_LIM) begin
                    timeout_err_d = 1'b1;
                    last_d        = owner_q;
                    timer_d       = '0;
                    state_d       = ST_GAP;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ST_RESP: begin
                last_d  = owner_q;
                timer_d = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if ((timer_q >= GAP_LIM) && !spi_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            spi_data_q    <= 8'h00;
            rdata_q       <= 8'h00;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            rvalid_a_q    <= 1'b0;
            rvalid_b_q    <= 1'b0;
            spi_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            arb_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            spi_data_q    <= spi_data_d;
            rdata_q       <= rdata_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            gnt_a_q       <= gnt_a_d;
            gnt_b_q       <= gnt_b_d;
            rvalid_a_q    <= rvalid_a_d;
            rvalid_b_q    <= rvalid_b_d;
            spi_valid_q   <= spi_valid_d;
            timeout_err_q <= timeout_err_d;
            arb_busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign gnt_a       = gnt_a_q;
    assign gnt_b       = gnt_b_q;
    assign rvalid_a    = rvalid_a_q;
    assign rvalid_b    = rvalid_b_q;
    assign rdata       = rdata_q;
    assign spi_data    = spi_data_q;
    assign spi_valid   = spi_valid_q;
    assign timeout_err = timeout_err_q;
    assign owner       = owner_q;
    assign arb_busy    = arb_busy_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: stimulus pushes expected grants,
// responses and timeout latencies; a monitor pops and compares them.
module tb_spi_xfer_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata, spi_data;
    logic       spi_valid, spi_busy, spi_done;
    logic [7:0] spi_rddata;
    logic       timeout_err, owner, arb_busy;

    spi_xfer_arbiter #(
        .GAP_CYCLES(4),
        .START_TO  (16),
        .DONE_TO   (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .data_a     (data_a),
        .gnt_a      (gnt_a),
        .rvalid_a   (rvalid_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .gnt_b      (gnt_b),
        .rvalid_b   (rvalid_b),
        .rdata      (rdata),
        .spi_data   (spi_data),
        .spi_valid  (spi_valid),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .spi_rddata (spi_rddata),
        .timeout_err(timeout_err),
        .owner      (owner),
        .arb_busy   (arb_busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;

    exp_t gnt_exp[$];
    exp_t rsp_exp[$];
    int   to_exp[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_cyc = 0;
    int n_valid  = 0;

    // engine model controls: 0 normal, 1 never busy, 2 busy forever, 3 double done
    int         eng_mode  = 0;
    int         busy_dly  = 2;
    int         done_dly  = 5;
    logic [7:0] eng_xor   = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_gnt(input logic p, input logic [7:0] d);
        exp_t e;
        e.port = p; e.data = d;
        gnt_exp.push_back(e);
    endtask

    task automatic push_rsp(input logic p, input logic [7:0] d);
        exp_t e;
        e.port = p; e.data = d;
        rsp_exp.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt_a"},    32'(gnt_a),       32'd0);
        chk({tag, "_gnt_b"},    32'(gnt_b),       32'd0);
        chk({tag, "_rvalid"},   32'(rvalid_a | rvalid_b), 32'd0);
        chk({tag, "_rdata"},    32'(rdata),       32'd0);
        chk({tag, "_spi_data"}, 32'(spi_data),    32'd0);
        chk({tag, "_spi_valid"},32'(spi_valid),   32'd0);
        chk({tag, "_timeout"},  32'(timeout_err), 32'd0);
        chk({tag, "_owner"},    32'(owner),       32'd0);
        chk({tag, "_arb_busy"}, 32'(arb_busy),    32'd0);
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt_a || gnt_b) && n < 500);
        chk({name, "_gnt_seen"}, 32'(gnt_a || gnt_b), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (arb_busy && n < 3000);
        chk({name, "_idle"}, 32'(arb_busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Engine model: reacts to spi_valid with busy/done per eng_mode.
    initial begin
        logic [7:0] tx;
        int cnt;
        spi_busy = 1'b0; spi_done = 1'b0; spi_rddata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && spi_valid) begin
                tx = spi_data;
                if (eng_mode == 0 || eng_mode == 3) begin
                    repeat (busy_dly) @(negedge clk);
                    spi_busy = 1'b1;
                    repeat (done_dly) @(negedge clk);
                    spi_done = 1'b1; spi_rddata = tx ^ eng_xor;
                    @(negedge clk);
                    spi_done = 1'b0; spi_busy = 1'b0; spi_rddata = 8'h00;
                    if (eng_mode == 3) begin
                        repeat (2) @(negedge clk);
                        spi_done = 1'b1; spi_rddata = tx ^ 8'h0F;
                        @(negedge clk);
                        spi_done = 1'b0; spi_rddata = 8'h00;
                    end
                end else if (eng_mode == 2) begin
                    spi_busy = 1'b1;
                    cnt = 0;
                    while (cnt < 5000 && rst_n && !timeout_err) begin
                        @(negedge clk);
                        cnt++;
                    end
                    spi_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every grant, response and timeout against the scoreboard.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (spi_valid) begin
                    valid_cyc = cyc;
                    n_valid++;
                end
                if (gnt_a && gnt_b) begin
                    chk("gnt_overlap", 32'd1, 32'd0);
                end else if (gnt_a || gnt_b) begin
                    if (gnt_exp.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt_b), 32'hFFFF);
                    end else begin
                        e = gnt_exp.pop_front();
                        chk("gnt_port", 32'(gnt_b),    32'(e.port));
                        chk("gnt_data", 32'(spi_data), 32'(e.data));
                        chk("gnt_owner", 32'(owner),   32'(e.port));
                    end
                end
                if (rvalid_a && rvalid_b) begin
                    chk("rvalid_overlap", 32'd1, 32'd0);
                end else if (rvalid_a || rvalid_b) begin
                    if (rsp_exp.size() == 0) begin
                        chk("rvalid_unexpected", 32'(rdata), 32'hFFFF);
                    end else begin
                        e = rsp_exp.pop_front();
                        chk("rvalid_port", 32'(rvalid_b), 32'(e.port));
                        chk("rvalid_rdata", 32'(rdata),   32'(e.data));
                    end
                end
                if (timeout_err) begin
                    if (to_exp.size() == 0) begin
                        chk("timeout_unexpected", 32'd1, 32'd0);
                    end else begin
                        lat = to_exp.pop_front();
                        chk("timeout_latency", 32'(cyc - valid_cyc), 32'(lat));
                    end
                end
            end
        end
    end

    // Watchdog: hard stop if the run gets stuck.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Contested: pointer favours A after reset, so A,B,A,B; engine inverts.
        eng_mode = 0; eng_xor = 8'hFF; busy_dly = 2; done_dly = 5;
        push_gnt(1'b0, 8'h11); push_rsp(1'b0, 8'hEE);
        push_gnt(1'b1, 8'h22); push_rsp(1'b1, 8'hDD);
        push_gnt(1'b0, 8'h11); push_rsp(1'b0, 8'hEE);
        push_gnt(1'b1, 8'h22); push_rsp(1'b1, 8'hDD);
        data_a = 8'h11; data_b = 8'h22; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 4; i++) wait_gnt("rr");
        req_a = 1'b0; req_b = 1'b0;
        wait_idle("rr");

        // Single A: 0xA5 ^ 0x99 = 0x3C, busy after 2, done 40 later.
        eng_xor = 8'h99; done_dly = 40;
        push_gnt(1'b0, 8'hA5); push_rsp(1'b0, 8'h3C);
        data_a = 8'hA5; req_a = 1'b1;
        wait_gnt("single_a");
        req_a = 1'b0;
        wait_idle("single_a");
        chk("single_a_rdata", 32'(rdata), 32'h3C);
        chk("single_a_owner", 32'(owner), 32'd0);

        // Engine never busy: abort 16 cycles after spi_valid.
        eng_mode = 1;
        push_gnt(1'b1, 8'h5E); to_exp.push_back(16);
        data_b = 8'h5E; req_b = 1'b1;
        wait_gnt("start_to");
        req_b = 1'b0;
        wait_idle("start_to");
        chk("start_to_rdata_hold", 32'(rdata), 32'h3C);

        // Busy forever: busy seen on the first WAIT_BUSY cycle, then 64 in WAIT_DONE.
        eng_mode = 2;
        push_gnt(1'b0, 8'h6D); to_exp.push_back(65);
        data_a = 8'h6D; req_a = 1'b1;
        wait_gnt("done_to");
        req_a = 1'b0;
        wait_idle("done_to");
        chk("done_to_rdata_hold", 32'(rdata), 32'h3C);

        // Contested after A aborted: B wins; double done gives one rvalid, first data.
        eng_mode = 3; done_dly = 5;
        push_gnt(1'b1, 8'h4B); push_rsp(1'b1, 8'hD2);
        data_a = 8'h11; data_b = 8'h4B; req_a = 1'b1; req_b = 1'b1;
        wait_gnt("dbl");
        req_a = 1'b0; req_b = 1'b0;
        wait_idle("dbl");
        repeat (6) @(negedge clk);
        chk("dbl_rdata", 32'(rdata), 32'hD2);

        // Reset in WAIT_DONE, release with req_b high.
        eng_mode = 2;
        push_gnt(1'b0, 8'h33);
        data_a = 8'h33; req_a = 1'b1;
        wait_gnt("rst_mid");
        req_a = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_mid_busy", 32'(spi_busy), 32'd1);
        rst_n = 1'b0; data_b = 8'h77; req_b = 1'b1;
        #1;
        check_reset("rst_mid");
        eng_mode = 0;
        repeat (3) @(negedge clk);
        push_gnt(1'b1, 8'h77); push_rsp(1'b1, 8'hEE);
        rst_n = 1'b1;
        wait_gnt("post_rst");
        req_b = 1'b0;
        @(negedge clk);
        chk("post_rst_spi_valid", 32'(spi_valid), 32'd1);
        wait_idle("post_rst");
        chk("post_rst_rdata", 32'(rdata), 32'hEE);

        // Final bookkeeping.
        chk("spi_valid_cycles", 32'(n_valid), 32'd10);
        chk("gnt_queue_empty", 32'(gnt_exp.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rsp_exp.size()), 32'd0);
        chk("to_queue_empty",  32'(to_exp.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares the single spi_top byte engine between two requesters: port A (FIFO-fed stream path) and port B (configuration/register path).
- Round-robin arbitration, one byte transfer at a time.
- Issues the 1-cycle valid strobe to the engine and waits for busy, then done, with timeouts.
- Returns the received byte to the winning requester and enforces a minimum inter-byte gap.

Parameters:
- GAP_CYCLES, 4, idle cycles forced between end of one transfer and next grant (>=1).
- START_TO, 16, max cycles from spi_valid until spi_busy or spi_done is seen.
- DONE_TO, 2048, max cycles in WAIT_DONE before abort.

Ports:
- Clk  in  1  system clock (50 MHz domain).
- Rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  port A request; held high until gnt_a.
- data_a  in  8  port A transmit byte; valid while req_a.
- gnt_a  out  1  1-cycle pulse; data_a consumed.
- rvalid_a  out  1  1-cycle pulse; rdata holds port A's received byte.
- req_b  in  1  port B request; held high until gnt_b.
- data_b  in  8  port B transmit byte.
- gnt_b  out  1  1-cycle pulse; data_b consumed.
- rvalid_b  out  1  1-cycle pulse; rdata holds port B's received byte.
- rdata  out  8  last successfully received byte.
- spi_data  out  8  byte to engine; stable from ISSUE until return to IDLE.
- spi_valid  out  1  1-cycle start strobe to engine.
- spi_busy  in  1  engine busy.
- spi_done  in  1  engine receive-done pulse.
- spi_rddata  in  8  engine received byte; valid with spi_done.
- timeout_err  out  1  1-cycle pulse on aborted transfer.
- owner  out  1  current/last owner (0=A, 1=B).
- arb_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all pulses 0, rdata=0, spi_data=0, owner=0, arb_busy=0. State=IDLE. Round-robin pointer favours A first.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, GAP.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant the port that did not win last (the pointer).
  - On grant: gnt_x=1 the same cycle, latch data_x into spi_data, set owner, go ISSUE.
- ISSUE: spi_valid=1 for exactly one cycle. Clear the timer. Go WAIT_BUSY.
- WAIT_BUSY:
  - spi_done=1: capture and go RESP (fast engine case).
  - spi_busy=1: go WAIT_DONE, clear the timer.
  - Timer reaches START_TO: abort.
- WAIT_DONE:
  - First spi_done=1: rdata<=spi_rddata, go RESP.
  - Timer reaches DONE_TO: abort.
- RESP: rvalid_owner=1 for one cycle. Pointer<=owner. Go GAP.
- Abort:
  - timeout_err=1 for one cycle; no rvalid; rdata unchanged.
  - Pointer<=owner, so the other port is favoured next. Go GAP.
- GAP: count GAP_CYCLES, then also wait for spi_busy=0. Then IDLE.
- Minimum grant-to-grant spacing = 1+1+1+1+GAP_CYCLES+1 cycles (plus engine time).
- spi_done outside WAIT_BUSY/WAIT_DONE is ignored. This includes a second done pulse, which is deduplicated.
- At most one gnt per transfer; gnt_a and gnt_b are never high together. Likewise rvalid_a and rvalid_b.
- req dropped after gnt has no effect on the transfer in flight.
- Timer width: clog2(max(START_TO,DONE_TO))+1; it saturates and does not wrap.
- Rst_n low mid-transfer: immediate return to reset values. No pulse is emitted on release; the engine is reset by the same Rst_n.

Test Plan:
- Single A request, data_a=0xA5; engine raises busy 2 cycles after spi_valid and pulses done 40 cycles later with spi_rddata=0x3C -> gnt_a one pulse, spi_data=0xA5, spi_valid one pulse, rvalid_a one pulse, rdata=0x3C, owner=0.
- req_a and req_b both held for 4 transfers, data_a=0x11, data_b=0x22 -> grant order A,B,A,B. spi_data alternates 0x11/0x22. No overlapping gnt.
- Engine never raises busy -> timeout_err pulse exactly START_TO cycles after WAIT_BUSY entry, no rvalid, rdata holds its previous value, arbiter returns to IDLE after GAP.
- busy held high with no done, DONE_TO=64 -> timeout_err at cycle 64 of WAIT_DONE. The next contested grant goes to the other port.
- Done pulsed twice, 3 cycles apart -> exactly one rvalid; rdata is from the first pulse.
- Rst_n asserted mid-WAIT_DONE, then released with req_b high -> all outputs at reset values; first grant after release is gnt_b with a fresh spi_valid.
